// File: rtl/pipe_skid_pkg.sv
// Shared definitions for the pipe_skid two-entry skid buffer: state encodings,
// reset polarity and the state-to-occupancy mapping.
package pipe_skid_pkg;

  localparam logic RST_ACTIVE = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_of(input skid_state_e st);
    logic [1:0] n;
    n = 2'd0;
    case (st)
      ST_EMPTY: n = 2'd0;
      ST_BUSY:  n = 2'd1;
      ST_FULL:  n = 2'd2;
      default:  n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pipe_skid_entry.sv
// skid_entry: one payload register of the skid buffer; written only on its
// write enable and intentionally not reset (contents are don't-care when invalid).
module skid_entry
  import pipe_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] data_d;
  logic [DATA_WIDTH-1:0] data_q;

  always_comb begin
    data_d = data_q;
    if (we) data_d = d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/pipe_skid.sv
// pipe_skid: two-entry valid/ready skid buffer with pin_ready and pout_valid
// both driven from flops. Optional flush port under PIPE_SKID_FLUSH_EN.
module pipe_skid
  import pipe_skid_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pin_valid,
  input  logic [DATA_WIDTH-1:0] pin_data,
  output logic                  pin_ready,
  output logic                  pout_valid,
  output logic [DATA_WIDTH-1:0] pout_data,
  input  logic                  pout_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic                  flush,
`endif
  output logic [1:0]            occ
);

  skid_state_e state_d, state_q;
  logic        pin_ready_d, pin_ready_q;
  logic        pout_valid_d, pout_valid_q;

  logic        up_xfer;
  logic        dn_xfer;
  logic        main_we;
  logic        skid_we;
  logic        main_from_skid;
  logic        flush_req;

  logic [DATA_WIDTH-1:0] main_in;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] skid_q;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign up_xfer = pin_valid & pin_ready_q;
  assign dn_xfer = pout_valid_q & pout_ready;

  always_comb begin
    state_d        = state_q;
    main_we        = 1'b0;
    skid_we        = 1'b0;
    main_from_skid = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (up_xfer) begin
          main_we = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (up_xfer && dn_xfer) begin
          main_we = 1'b1;
        end else if (up_xfer) begin
          skid_we = 1'b1;
          state_d = ST_FULL;
        end else if (dn_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // pin_ready is low here, so only the downstream side can move.
        if (dn_xfer) begin
          main_we        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Flush drops everything in flight; upstream still sees its handshake.
    if (flush_req) begin
      state_d = ST_EMPTY;
      main_we = 1'b0;
      skid_we = 1'b0;
    end

    pin_ready_d  = (state_d != ST_FULL);
    pout_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state_q      <= ST_EMPTY;
      pin_ready_q  <= 1'b1;
      pout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pin_ready_q  <= pin_ready_d;
      pout_valid_q <= pout_valid_d;
    end
  end

  assign main_in = main_from_skid ? skid_q : pin_data;

  skid_entry #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_main (
    .clk (clk),
    .we  (main_we),
    .d   (main_in),
    .q   (main_q)
  );

  skid_entry #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk (clk),
    .we  (skid_we),
    .d   (pin_data),
    .q   (skid_q)
  );

  assign pin_ready  = pin_ready_q;
  assign pout_valid = pout_valid_q;
  assign pout_data  = main_q & {DATA_WIDTH{pout_valid_q}};
  assign occ        = occ_of(state_q);

endmodule

// File: tb/tb_pipe_skid.sv
// Testbench for pipe_skid: directed steps then random traffic, checked against
// a queue-based FIFO reference model. Define PIPE_SKID_FLUSH_EN to cover flush.
module tb_pipe_skid;

  localparam int DW = 32;
`ifdef PIPE_SKID_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          pin_valid;
  logic [DW-1:0] pin_data;
  logic          pin_ready;
  logic          pout_valid;
  logic [DW-1:0] pout_data;
  logic          pout_ready;
  logic [1:0]    occ;
`ifdef PIPE_SKID_FLUSH_EN
  logic          flush;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];

  pipe_skid #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .pin_valid  (pin_valid),
    .pin_data   (pin_data),
    .pin_ready  (pin_ready),
    .pout_valid (pout_valid),
    .pout_data  (pout_data),
    .pout_ready (pout_ready),
`ifdef PIPE_SKID_FLUSH_EN
    .flush      (flush),
`endif
    .occ        (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model: a FIFO of at most two beats.
  task automatic check_model(input string ctx);
    logic [DW-1:0] exp_data;
    exp_data = (mq.size() > 0) ? mq[0] : '0;
    chk({ctx, ".pin_ready"},  {31'd0, pin_ready},  {31'd0, (mq.size() < 2)});
    chk({ctx, ".pout_valid"}, {31'd0, pout_valid}, {31'd0, (mq.size() > 0)});
    chk({ctx, ".pout_data"},  pout_data, exp_data);
    chk({ctx, ".occ"},        {30'd0, occ}, DW'(mq.size()));
  endtask

  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr,
                       input logic fl, input logic r, input string ctx, output logic acc);
    logic up, dn;
    pin_valid  = pv;
    pin_data   = pd;
    pout_ready = pr;
    rst        = r;
`ifdef PIPE_SKID_FLUSH_EN
    flush      = fl;
`endif
    up = pv && (mq.size() < 2);
    dn = pr && (mq.size() > 0);
    acc = up;
    @(posedge clk);
    #1;
    if (r) begin
      mq.delete();
    end else if (fl && FLUSH_ON) begin
      mq.delete();
    end else begin
      if (dn) void'(mq.pop_front());
      if (up) mq.push_back(pd);
    end
    check_model(ctx);
  endtask

  initial begin
    logic acc;
    logic pend;
    logic pv_r, pr_r, fl_r, rst_r;
    logic [DW-1:0] pd_r;

    pin_valid = 1'b0; pin_data = '0; pout_ready = 1'b0; rst = 1'b1;
`ifdef PIPE_SKID_FLUSH_EN
    flush = 1'b0;
`endif

    // Reset
    cycle(0, 0, 0, 0, 1, "rst0", acc);
    cycle(0, 0, 0, 0, 1, "rst1", acc);
    chk("reset.pin_ready", {31'd0, pin_ready}, 32'd1);
    chk("reset.pout_valid", {31'd0, pout_valid}, 32'd0);
    chk("reset.pout_data", pout_data, 32'd0);
    chk("reset.occ", {30'd0, occ}, 32'd0);

    // Single beat latency
    cycle(1, 32'hA5A5A5A5, 1, 0, 0, "lat", acc);
    chk("lat.data", pout_data, 32'hA5A5A5A5);
    chk("lat.valid", {31'd0, pout_valid}, 32'd1);
    chk("lat.occ", {30'd0, occ}, 32'd1);
    chk("lat.ready", {31'd0, pin_ready}, 32'd1);

    // Back-to-back stream
    for (int i = 1; i <= 8; i++) begin
      cycle(1, DW'(i), 1, 0, 0, "stream", acc);
      chk("stream.data", pout_data, DW'(i));
      chk("stream.ready", {31'd0, pin_ready}, 32'd1);
    end
    cycle(0, 0, 1, 0, 0, "drain0", acc);
    chk("drain0.occ", {30'd0, occ}, 32'd0);

    // Backpressure: two beats accepted, third held upstream
    cycle(1, 32'h10, 0, 0, 0, "bp0", acc);
    cycle(1, 32'h11, 0, 0, 0, "bp1", acc);
    chk("bp1.ready", {31'd0, pin_ready}, 32'd0);
    chk("bp1.occ", {30'd0, occ}, 32'd2);
    cycle(1, 32'h12, 0, 0, 0, "bp2", acc);
    chk("bp2.acc", {31'd0, acc}, 32'd0);
    chk("bp2.hold", pout_data, 32'h10);
    cycle(1, 32'h12, 1, 0, 0, "bp3", acc);
    chk("bp3.data", pout_data, 32'h11);
    cycle(1, 32'h12, 1, 0, 0, "bp4", acc);
    chk("bp4.data", pout_data, 32'h12);
    cycle(0, 0, 1, 0, 0, "bp5", acc);
    chk("bp5.valid", {31'd0, pout_valid}, 32'd0);

    // Single drain pulse out of FULL
    cycle(1, 32'h20, 0, 0, 0, "full0", acc);
    cycle(1, 32'h21, 0, 0, 0, "full1", acc);
    cycle(0, 0, 1, 0, 0, "full2", acc);
    chk("full2.data", pout_data, 32'h21);
    chk("full2.occ", {30'd0, occ}, 32'd1);
    chk("full2.ready", {31'd0, pin_ready}, 32'd1);
    cycle(0, 0, 1, 0, 0, "full3", acc);

`ifdef PIPE_SKID_FLUSH_EN
    // Flush from FULL with concurrent transfers
    cycle(1, 32'h30, 0, 0, 0, "fl0", acc);
    cycle(1, 32'h31, 0, 0, 0, "fl1", acc);
    cycle(1, 32'h33, 1, 1, 0, "fl2", acc);
    chk("flush.valid", {31'd0, pout_valid}, 32'd0);
    chk("flush.data", pout_data, 32'd0);
    chk("flush.occ", {30'd0, occ}, 32'd0);
    chk("flush.ready", {31'd0, pin_ready}, 32'd1);
    cycle(0, 0, 1, 0, 0, "fl3", acc);
    chk("flush.no33", {31'd0, pout_valid}, 32'd0);
`endif

    // Reset while BUSY with an incoming beat
    cycle(1, 32'h40, 0, 0, 0, "rb0", acc);
    cycle(1, 32'h41, 1, 0, 1, "rb1", acc);
    chk("rstbusy.valid", {31'd0, pout_valid}, 32'd0);
    chk("rstbusy.data", pout_data, 32'd0);
    chk("rstbusy.occ", {30'd0, occ}, 32'd0);
    chk("rstbusy.ready", {31'd0, pin_ready}, 32'd1);

    // Random traffic; upstream holds a refused beat until it is taken
    pend = 1'b0;
    pv_r = 1'b0;
    pd_r = '0;
    for (int k = 0; k < 600; k++) begin
      if (!pend) begin
        pv_r = ($urandom_range(0, 3) != 0);
        pd_r = $urandom;
      end
      pr_r  = ($urandom_range(0, 2) != 0);
      fl_r  = FLUSH_ON && ($urandom_range(0, 31) == 0);
      rst_r = ($urandom_range(0, 79) == 0);
      cycle(pv_r, pd_r, pr_r, fl_r, rst_r, "rand", acc);
      pend = pv_r && !acc && !rst_r && !fl_r;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid.md
# pipe_skid

Two-entry skid buffer for the valid/ready handshake used between NPC core pipeline stages. It complements the forward-registered valid stage: both `pout_valid`/`pout_data` and the upstream `pin_ready` leave this block straight from flops, so no combinational path runs from `pout_ready` back to `pin_ready`. It sits at stage boundaries where the backpressure path is timing-critical, e.g. IFU→IDU and LSU→WBU.

## Interface
- `DATA_WIDTH`, default 32: payload width in bits.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rst` input, 1: reset `rst`, synchronous, active-high.
- `pin_valid` input, 1: upstream beat valid.
- `pin_data` input, DATA_WIDTH: upstream payload.
- `pin_ready` output, 1: registered; block can accept a beat this cycle.
- `pout_valid` output, 1: registered; downstream beat valid.
- `pout_data` output, DATA_WIDTH: downstream payload; all-zero whenever `pout_valid`=0.
- `pout_ready` input, 1: downstream accepts the beat.
- `occ` output, 2: entries held (0, 1 or 2).
- `flush` input, 1: present only with `PIPE_SKID_FLUSH_EN`; discards all held beats.

## Operation
- Storage: a main entry (drives `pout_*`) and a skid entry. Upstream transfer is `pin_valid & pin_ready`; downstream transfer is `pout_valid & pout_ready`.
- States: EMPTY (occ=0), BUSY (main only, occ=1), FULL (main+skid, occ=2).
- EMPTY: on an upstream transfer, main <= `pin_data` -> BUSY; otherwise stay.
- BUSY, by (upstream transfer, downstream transfer):
  - (1,1): main <= `pin_data`; stay in BUSY.
  - (1,0): skid <= `pin_data` -> FULL.
  - (0,1): -> EMPTY.
  - (0,0): hold.
- FULL: `pin_ready`=0, so no upstream transfer is possible. On a downstream transfer, main <= skid -> BUSY; otherwise hold.
- `pin_ready` = (state != FULL), taken from a flop updated with the next state.
- `pout_valid` = (state != EMPTY).
- `pout_data` = main & {DATA_WIDTH{pout_valid}}.
- Beat order is strictly FIFO. No beat is dropped or duplicated except by flush.
- Data registers update only on their write enables. Their contents are don't-care while the entry is invalid.
- `pin_valid` asserted with `pin_ready`=0 is ignored; upstream must hold the beat.
- `pout_valid` and `pout_data` stay stable while `pout_valid`=1 and `pout_ready`=0.

## Timing
- Reset values: state EMPTY, `pin_ready`=1, `pout_valid`=0, `pout_data`=0, `occ`=0. Data flops are not reset.
- Latency: a beat accepted in cycle N appears on `pout_*` in cycle N+1 when the block was EMPTY.
- Throughput: one beat per cycle sustained while `pout_ready`=1.
- After `pout_ready` drops, at most one further beat is accepted (into skid). `pin_ready` falls in the cycle after that acceptance.
- `pin_ready` returns to 1 in the cycle after the first downstream transfer out of FULL.
- Reset mid-operation returns to EMPTY next cycle. In-flight beats are lost, and `rst` overrides `flush` and all transfers.

## Configuration
- Macro: `PIPE_SKID_FLUSH_EN`.
- Defined:
  - The `flush` port exists.
  - `flush`=1 forces EMPTY next cycle, with `pin_ready`=1, `pout_valid`=0 and `occ`=0.
  - Any upstream or downstream transfer in the flush cycle is discarded. Upstream still sees its handshake complete.
  - `flush` has priority over everything except `rst`.
- Undefined: the `flush` port and its logic are absent; behaviour is otherwise identical.

## Structure
- The shared core defines header/package holds:
  - the state encodings (EMPTY=2'd0, BUSY=2'd1, FULL=2'd2) as constants;
  - the existing active-high reset-enable constant, used for the `rst` comparison.
- One sub-module, `skid_entry`: a DATA_WIDTH register with write enable and no reset. It is instantiated twice, as main and skid.
- The state machine, `pin_ready` flop and output masking live in `pipe_skid`.

## Test plan
- Reset, then `pin_valid`=1 with data 0xA5A5A5A5 and `pout_ready`=1. Expect `pout_valid`=1 and `pout_data`=0xA5A5A5A5 in the next cycle, `occ`=1 and `pin_ready` staying 1.
- Stream 0x1..0x8 on back-to-back cycles with `pout_ready`=1. Expect 0x1..0x8 in order, one per cycle, one cycle delayed, with `pin_ready` constantly 1.
- Stream 0x10, 0x11, 0x12 with `pout_ready`=0:
  - 0x10 and 0x11 are accepted, then `pin_ready`=0 and `occ`=2, and 0x12 is held upstream.
  - `pout_data` holds 0x10.
  - Raise `pout_ready`: expect 0x10, 0x11, 0x12 in order.
- In FULL (0x20 main, 0x21 skid), pulse `pout_ready` for one cycle. Expect 0x21 on `pout_data`, `occ`=1 and `pin_ready`=1 in the next cycle.
- With `PIPE_SKID_FLUSH_EN`: fill to FULL, then assert `flush` together with `pout_ready`=1 and `pin_valid`=1 carrying 0x33. Expect `pout_valid`=0, `pout_data`=0, `occ`=0 and `pin_ready`=1 in the next cycle, and 0x33 never emitted.
- Assert `rst` for one cycle while in BUSY with `pin_valid`=1. Expect all outputs at their reset values in the next cycle.
